lux_data_gen: RTL and testbench
===============================

# lux_data_gen

Parametrised successor to the BH1750 display data generator, sitting between the BH1750 I2C reader and the six-digit seven-segment driver. It accepts raw 16-bit light samples with a valid strobe and keeps a moving average over a power-of-two window. It converts the average to lux (×10/12, or ×100/12 with one decimal in high-resolution mode) using a multi-cycle sequential divider, saturates to the display maximum, and blanks the display when samples stop arriving.

## Interface
- AVG_LOG2, 2: averaging window = 2^AVG_LOG2 samples; legal range 0..4.
- DATA_MAX, 20'd999_999: saturation ceiling for `data`.
- CNT_MAX, 23'd4_999_999: stale timeout in clocks (100 ms at 50 MHz).
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  reset, asynchronous, active-high.
- data_in  in  16  raw BH1750 count.
- data_in_valid  in  1  one-cycle sample strobe.
- hres  in  1  0: integer lux; 1: lux with one decimal place.
- busy  out  1  conversion in progress; samples offered while high are dropped.
- overrun  out  1  one-cycle pulse when a sample is dropped.
- data  out  20  value for the display (binary).
- data_valid  out  1  one-cycle pulse when `data`/`point` update.
- point  out  6  decimal-point mask, high = lit.
- seg_en  out  1  display enable.
- sign  out  1  tied 0.

## Operation
- **Reset (asynchronous, any state):**
  - Outputs: data=0, point=0, data_valid=0, overrun=0, busy=0, seg_en=0.
  - Internal state: FSM=IDLE, buffer-primed flag cleared, stale counter=0.
- **FSM states:** IDLE → UPDATE → MUL → DIV → OUT → IDLE.
- **IDLE:**
  - Sample accepted on an edge where data_in_valid=1 and busy=0.
  - Latches data_in and hres, clears the stale counter, moves to UPDATE.
- **UPDATE:**
  - Circular buffer holds 2^AVG_LOG2 × 16 bits; running sum is 16+AVG_LOG2 bits.
  - First sample after reset (primed=0): every entry is set to the sample, sum = sample << AVG_LOG2, primed=1.
  - Otherwise: sum <= sum + new − entry[wr_ptr]; entry[wr_ptr] <= new; wr_ptr increments and wraps from 2^AVG_LOG2−1 to 0.
- **MUL:**
  - avg = sum >> AVG_LOG2 (truncating).
  - product (23 bits) = avg×10 when hres=0, avg×100 when hres=1.
- **DIV:**
  - Restoring divide by constant 12, one quotient bit per clock, 23 iterations.
  - Quotient is truncated; the remainder is discarded.
- **OUT:**
  - data <= min(quotient, DATA_MAX).
  - point <= 6'b000_010 when hres=1, else 6'b000_000.
  - data_valid <= 1 for one cycle; seg_en <= 1.
- **Dropped samples:** data_in_valid while busy=1 → the sample is discarded, overrun pulses the following cycle, and no buffer or FSM change occurs.
- **Stale timeout:**
  - The counter increments every cycle in which no sample is accepted and saturates at CNT_MAX.
  - On reaching CNT_MAX, seg_en <= 0. seg_en re-asserts only with the next data_valid.
  - data holds its last value while stale.
- sign is always 0.

## Timing
- Accept edge N:
  - busy=1 after edge N.
  - UPDATE completes at N+1, MUL at N+2.
  - DIV iterations occupy edges N+3..N+25.
  - OUT registers at N+26: data_valid=1 and busy=0 after N+26.
- Latency is 26 clocks from the accept edge to data_valid.
- Maximum sustained rate is one sample per 27 clocks.
- A sample offered in the same cycle that data_valid is high is accepted (busy is already 0).
- data and point are stable between data_valid pulses.
- overrun is asserted the cycle after the dropping edge.
- Stale counter and busy are independent.
- A timeout reached during a conversion still clears seg_en; that conversion's data_valid sets it again.

## Test plan
- **Reset:** assert sys_rst mid-DIV → all outputs 0 immediately; the next sample is treated as first (prefill), e.g. 1200 → data=1000.
- **First sample:** AVG_LOG2=2, hres=0, data_in=1200 → data=1000, point=000000, data_valid exactly 26 clocks after accept, seg_en=1.
- **Averaging/wrap:** samples 1200, then 2400 ×4 → data sequence 1000, 1250, 1500, 1750, 2000. The fifth sample exercises wr_ptr wrap.
- **High-res and saturation:** hres=1, data_in=16'hFFFF → data=546125, point=000010. Same stimulus with DATA_MAX=20'd99_999 → data=99999.
- **Overrun:** second data_in_valid 5 clocks after accept → overrun pulses once; the result equals the first sample only; busy timing is unchanged.
- **Stale:** CNT_MAX=100, no samples for 100 clocks after a conversion → seg_en=0 and data unchanged. Next sample 2400 (primed buffer [1200×4]) → data=1250 and seg_en=1 on data_valid.

Source files
------------

// File: rtl/lux_data_gen.sv
// BH1750 display data generator: moving-average light samples, scale to lux with a
// bit-serial divide-by-12, saturate for the six-digit display and blank on stale input.
module lux_data_gen #(
    parameter int          AVG_LOG2 = 2,
    parameter logic [19:0] DATA_MAX = 20'd999_999,
    parameter logic [22:0] CNT_MAX  = 23'd4_999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] data_in,
    input  logic        data_in_valid,
    input  logic        hres,
    output logic        busy,
    output logic        overrun,
    output logic [19:0] data,
    output logic        data_valid,
    output logic [5:0]  point,
    output logic        seg_en,
    output logic        sign
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SW    = 16 + AVG_LOG2;

    typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_MUL, S_DIV, S_OUT} state_t;

    state_t          r_state;
    logic [15:0]     r_sample;
    logic            r_hres;
    logic            r_primed;
    logic [PW-1:0]   r_ptr;
    logic [SW-1:0]   r_sum;
    logic [15:0]     r_buf [DEPTH];
    logic [22:0]     r_dvd;
    logic [22:0]     r_quo;
    logic [3:0]      r_rem;
    logic [4:0]      r_it;
    logic [22:0]     r_stale;
    logic            r_busy;
    logic            r_ovr;
    logic [19:0]     r_data;
    logic            r_dv;
    logic [5:0]      r_point;
    logic            r_seg_en;

    logic            w_accept;
    logic [15:0]     w_avg;
    logic [22:0]     w_prod;
    logic [4:0]      w_rem_sh;
    logic            w_ge;
    logic [3:0]      w_rem_nx;
    logic [19:0]     w_sat;
    logic            w_stale_hit;

    assign w_accept = data_in_valid & ~r_busy;
    assign w_avg    = r_sum[SW-1:AVG_LOG2];
    assign w_prod   = r_hres ? ({7'd0, w_avg} * 23'd100) : ({7'd0, w_avg} * 23'd10);

    // Restoring division step: remainder stays below 12, so 4 bits plus the shifted-in bit.
    assign w_rem_sh = {r_rem, r_dvd[22]};
    assign w_ge     = (w_rem_sh >= 5'd12);
    assign w_rem_nx = w_ge ? 4'(w_rem_sh - 5'd12) : w_rem_sh[3:0];
    assign w_sat    = (r_quo > {3'd0, DATA_MAX}) ? DATA_MAX : r_quo[19:0];

    // Timeout clears seg_en only on the edge it is reached, so a later data_valid can re-enable.
    assign w_stale_hit = ~w_accept && (r_stale == CNT_MAX - 23'd1);

    always_ff @(posedge sys_clk) begin
        if (r_state == S_UPDATE) begin
            if (!r_primed) begin
                for (int i = 0; i < DEPTH; i++) r_buf[i] <= r_sample;
            end else begin
                r_buf[r_ptr] <= r_sample;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= S_IDLE;
            r_sample <= '0;
            r_hres   <= 1'b0;
            r_primed <= 1'b0;
            r_ptr    <= '0;
            r_sum    <= '0;
            r_dvd    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_it     <= '0;
            r_stale  <= '0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
            r_data   <= '0;
            r_dv     <= 1'b0;
            r_point  <= '0;
            r_seg_en <= 1'b0;
        end else begin
            r_dv  <= 1'b0;
            r_ovr <= data_in_valid & r_busy;

            if (w_accept)               r_stale <= '0;
            else if (r_stale != CNT_MAX) r_stale <= r_stale + 23'd1;

            if (r_state == S_OUT)  r_seg_en <= 1'b1;
            else if (w_stale_hit)  r_seg_en <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sample <= data_in;
                        r_hres   <= hres;
                        r_busy   <= 1'b1;
                        r_state  <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (!r_primed) begin
                        r_sum    <= SW'(r_sample) << AVG_LOG2;
                        r_primed <= 1'b1;
                    end else begin
                        r_sum <= r_sum + SW'(r_sample) - SW'(r_buf[r_ptr]);
                        r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
                    end
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    r_dvd   <= w_prod;
                    r_quo   <= '0;
                    r_rem   <= '0;
                    r_it    <= '0;
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    r_dvd <= {r_dvd[21:0], 1'b0};
                    r_quo <= {r_quo[21:0], w_ge};
                    r_rem <= w_rem_nx;
                    r_it  <= r_it + 5'd1;
                    if (r_it == 5'd22) r_state <= S_OUT;
                end
                S_OUT: begin
                    r_data  <= w_sat;
                    r_point <= r_hres ? 6'b000_010 : 6'b000_000;
                    r_dv    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign overrun    = r_ovr;
    assign data       = r_data;
    assign data_valid = r_dv;
    assign point      = r_point;
    assign seg_en     = r_seg_en;
    assign sign       = 1'b0;
endmodule

// File: tb/tb_lux_data_gen.sv
// Scoreboard bench for lux_data_gen: a reference averager/scaler queues expected results
// at drive time and a negedge monitor pops them on every data_valid.
module tb_lux_data_gen;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic        hres = 1'b0;

    logic        busy, overrun, data_valid, seg_en, sign;
    logic [19:0] data;
    logic [5:0]  point;
    logic        busy2, overrun2, data_valid2, seg_en2, sign2;
    logic [19:0] data2;
    logic [5:0]  point2;

    lux_data_gen #(.AVG_LOG2(2), .DATA_MAX(20'd999_999), .CNT_MAX(23'd100)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_in(data_in),
        .data_in_valid(data_in_valid), .hres(hres), .busy(busy), .overrun(overrun),
        .data(data), .data_valid(data_valid), .point(point), .seg_en(seg_en), .sign(sign));

    lux_data_gen #(.AVG_LOG2(2), .DATA_MAX(20'd99_999)) dut_sat (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_in(data_in),
        .data_in_valid(data_in_valid), .hres(hres), .busy(busy2), .overrun(overrun2),
        .data(data2), .data_valid(data_valid2), .point(point2), .seg_en(seg_en2), .sign(sign2));

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        longint data;
        longint sdata;
        longint point;
        longint acc;
    } exp_t;

    exp_t        q[$];
    longint      hist[$];
    bit          primed = 0;
    int          n_run = 0;
    int          n_fail = 0;
    longint      cyc = 0;
    int          ovr_cnt = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: 4-entry window, prefilled by the first sample after reset.
    task automatic model_accept(input longint v, input bit h);
        exp_t   e;
        longint sum, quo;
        if (!primed) begin
            hist.delete();
            repeat (4) hist.push_back(v);
            primed = 1;
        end else begin
            hist.push_back(v);
            void'(hist.pop_front());
        end
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        quo     = ((sum / 4) * (h ? 100 : 10)) / 12;
        e.data  = (quo > 999999) ? 999999 : quo;
        e.sdata = (quo > 99999) ? 99999 : quo;
        e.point = h ? 2 : 0;
        e.acc   = cyc + 1;
        q.push_back(e);
    endtask

    // Called just after a negedge; the sample is presented for exactly one edge.
    task automatic send(input logic [15:0] v, input bit h);
        data_in       = v;
        hres          = h;
        data_in_valid = 1'b1;
        model_accept(v, h);
        @(negedge sys_clk);
        data_in_valid = 1'b0;
    endtask

    task automatic wait_dv();
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (data_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("dv_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        #2 sys_rst = 1'b1;
        #1;
        chk("rst_data", data, 0);
        chk("rst_point", point, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seg_en", seg_en, 0);
        chk("rst_overrun", overrun, 0);
        q.delete();
        primed = 0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst && overrun) ovr_cnt++;
        if (!sys_rst && data_valid) begin
            if (q.size() == 0) begin
                chk("spurious_dv", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data", data, e.data);
                chk("point", point, e.point);
                chk("seg_en_on_dv", seg_en, 1);
                chk("latency", cyc - e.acc, 26);
                chk("sat_dv", data_valid2, 1);
                chk("sat_data", data2, e.sdata);
            end
        end
    end

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("init_data", data, 0);
        chk("init_point", point, 0);
        chk("init_dv", data_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_seg_en", seg_en, 0);
        chk("init_overrun", overrun, 0);
        chk("sign", sign, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // First sample prefills the window, then back-to-back samples on the data_valid cycle.
        send(16'd1200, 1'b0);
        chk("busy_after_accept", busy, 1);
        wait_dv();
        chk("busy_at_dv", busy, 0);
        for (int k = 0; k < 4; k++) begin
            send(16'd2400, 1'b0);
            wait_dv();
        end
        repeat (3) @(negedge sys_clk);
        chk("data_hold", data, 2000);

        // A sample 5 clocks after accept is dropped with a single overrun pulse.
        ovr_cnt = 0;
        send(16'd4800, 1'b0);
        repeat (4) @(negedge sys_clk);
        data_in       = 16'd0;
        data_in_valid = 1'b1;
        @(negedge sys_clk);
        data_in_valid = 1'b0;
        chk("overrun_pulse", overrun, 1);
        chk("busy_during_drop", busy, 1);
        @(negedge sys_clk);
        chk("overrun_clear", overrun, 0);
        wait_dv();
        chk("overrun_count", ovr_cnt, 1);

        // Reset in the middle of a divide, then the next sample is a fresh prefill.
        send(16'd1200, 1'b0);
        repeat (10) @(negedge sys_clk);
        pulse_reset();
        send(16'd1200, 1'b0);
        wait_dv();

        // Stale timeout: 100 clocks from the accept blanks the display but keeps data.
        repeat (60) @(negedge sys_clk);
        chk("seg_en_before_stale", seg_en, 1);
        repeat (20) @(negedge sys_clk);
        chk("seg_en_stale", seg_en, 0);
        chk("data_stale_hold", data, 1000);
        chk("sat_seg_en_no_stale", seg_en2, 1);
        send(16'd2400, 1'b0);
        wait_dv();

        // High resolution at full scale, both ceilings.
        @(negedge sys_clk);
        pulse_reset();
        send(16'hFFFF, 1'b1);
        wait_dv();
        repeat (3) @(negedge sys_clk);
        chk("point_hold", point, 2);

        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
